cam_frame_capture: RTL

//  Camera-side capture stage feeding the 640x480 8-bit frame buffer RAM.

---
 rtl/cam_frame_capture_if.sv | 23 ++
 rtl/cam_frame_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_capture_if.sv
// Camera pixel bus plus frame-RAM write port for cam_frame_capture.
// master = capture block (reads camera, drives RAM writes); slave = camera/RAM side.
interface cam_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              cam_pclk_i;
  logic              cam_href_i;
  logic              cam_vsync_i;
  logic [7:0]        cam_data_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [7:0]        mem_dat_o;

  modport master (
    input  cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i,
    output mem_we_o, mem_adr_o, mem_dat_o
  );

  modport slave (
    output cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i,
    input  mem_we_o, mem_adr_o, mem_dat_o
  );
endinterface

// File: rtl/cam_frame_capture.sv
// OV7670-style RGB565 capture into an 8-bit frame buffer, sampled in the clk_i domain.
// Define CAM_GRAY_EN to store 8-bit luma instead of RGB332.
//
// state     | meaning
// S_IDLE    | waiting for start_i
// S_WAIT_VS | armed, waiting for vsync falling edge
// S_CAPTURE | storing pixels of the current frame
// S_DONE    | frame finished (done_o set), waiting for start_i
module cam_frame_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  cam_frame_capture_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int N_PIX = H_PIXELS * V_LINES;
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(N_PIX - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

  state_t state_q, state_nx;

  // Bit [1] is the synchronised level, bit [2] its previous value for edge detect.
  logic [2:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], bus.cam_pclk_i};
      href_sr  <= {href_sr[1:0], bus.cam_href_i};
      vsync_sr <= {vsync_sr[1:0], bus.cam_vsync_i};
      data_s1  <= bus.cam_data_i;
      data_s2  <= data_s1;
    end
  end

  logic sample_ev, href_s, href_fall, vs_fall, vs_rise;
  assign sample_ev = pclk_sr[1] & ~pclk_sr[2];
  assign href_s    = href_sr[1];
  assign href_fall = ~href_sr[1] & href_sr[2];
  assign vs_fall   = ~vsync_sr[1] & vsync_sr[2];
  assign vs_rise   = vsync_sr[1] & ~vsync_sr[2];

  logic [7:0] pix;
`ifdef CAM_GRAY_EN
  logic [7:0]  b1_q, b1_nx;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;
  logic [7:0]  r8, g8, b8;
  logic [10:0] y_sum;
  assign b1_nx = data_s2;
  assign r5    = b1_q[7:3];
  assign g6    = {b1_q[2:0], data_s2[7:5]};
  assign b5    = data_s2[4:0];
  assign r8    = {r5, r5[4:2]};
  assign g8    = {g6, g6[5:4]};
  assign b8    = {b5, b5[4:2]};
  assign y_sum = (11'(r8) << 1) + 11'(g8) * 11'd5 + 11'(b8);
  assign pix   = y_sum[10:3];
`else
  // Only the bits that survive RGB332 packing are kept from the first byte.
  logic [5:0] b1_q, b1_nx;
  assign b1_nx = {data_s2[7:5], data_s2[2:0]};
  assign pix   = {b1_q, data_s2[4:3]};
`endif

  logic              phase_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [7:0]        dat_q;
  logic              done_q, err_q;

  logic capture, last_wr, short_end, start_acc;
  assign capture   = (state_q == S_CAPTURE);
  assign last_wr   = capture & we_q & (adr_q == LAST_ADR);
  assign short_end = capture & ~last_wr & vs_rise;

  always_comb begin
    state_nx  = state_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_nx  = S_WAIT_VS;
          start_acc = 1'b1;
        end
      end
      S_WAIT_VS: begin
        if (vs_fall) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_wr || short_end) state_nx = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          state_nx  = S_WAIT_VS;
          start_acc = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      col_q   <= '0;
      addr_q  <= '0;
      b1_q    <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start_acc) begin
        addr_q <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (last_wr) done_q <= 1'b1;
      if (short_end) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if (!capture) begin
        phase_q <= 1'b0;
        col_q   <= '0;
      end else if (href_fall) begin
        phase_q <= 1'b0;
        col_q   <= '0;
      end else if (sample_ev && href_s) begin
        if (!phase_q) begin
          b1_q    <= b1_nx;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (col_q < COL_MAX) begin
            col_q <= col_q + COL_W'(1);
            // A pixel completing on the frame-ending vsync edge is not stored.
            if (!vs_rise) begin
              we_q   <= 1'b1;
              adr_q  <= addr_q;
              dat_q  <= pix;
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.mem_we_o  = we_q;
  assign bus.mem_adr_o = adr_q;
  assign bus.mem_dat_o = dat_q;
  assign busy_o = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign done_o = done_q;
  assign err_o  = err_q;
endmodule
